pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage (IF/ID/EX/MEM/WB) processor datapath, parametrised in register-address width and source-port count. It tracks a destination scoreboard for the EX, MEM and WB stages and generates PC/IF-ID enables, flushes and load-use stalls. It also produces registered per-source forwarding selects aligned with the instruction entering EX. It sits beside the ID stage; the datapath pipeline registers obey its enables and flushes.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_hazard_ctrl_src_match.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the five-stage pipeline hazard controller:
//   - forwarding select codes (FWD_RF / FWD_EXMEM / FWD_MEMWB)
//   - stage-record struct used for the EX, MEM and WB scoreboard entries
//   - REG_ZERO, the hard-wired zero register that never creates a hazard
// Record rw fields are REC_AW_MAX bits wide. Narrower register addresses are
// zero-extended into them, so the top supports REG_AW up to REC_AW_MAX.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int REC_AW_MAX = 8;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   localparam logic [REC_AW_MAX-1:0] REG_ZERO = 8'd0;

   typedef struct packed {
      logic                  valid;
      logic [REC_AW_MAX-1:0] rw;
      logic                  regwr;
      logic                  memtoreg;
   } stage_rec_t;

   localparam stage_rec_t REC_EMPTY = '{valid: 1'b0, rw: 8'd0, regwr: 1'b0, memtoreg: 1'b0};

   // A record can only be a hazard or forwarding source if it really writes a
   // non-zero register.
   function automatic logic rec_is_writer(input stage_rec_t rec);
      return rec.valid & rec.regwr & (rec.rw != REG_ZERO);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_src_match.sv
// -----------------------------------------------------------------------------
// src_match
// Compares one (zero-extended) ID source register against one stage record.
// Ports:
//   src   in  REC_AW_MAX  source register number
//   used  in  1           the source is actually read
//   rec   in  stage_rec_t stage record to compare against
//   hit   out 1           record is a writer of this source
// -----------------------------------------------------------------------------
module src_match
   import pipe_pkg::*;
(
   input  logic [REC_AW_MAX-1:0] src,
   input  logic                  used,
   input  stage_rec_t            rec,
   output logic                  hit
);

   assign hit = used & rec_is_writer(rec) & (rec.rw == src);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for a five-stage IF/ID/EX/MEM/WB pipeline.
// Keeps a destination scoreboard for EX, MEM and WB, produces PC / IF-ID
// enables, flushes and load-use stalls, and registered forwarding selects
// aligned with the instruction entering EX.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_src            N_SRC source registers, source s at [s*REG_AW +: REG_AW]
//   id_src_used       per-source "is read" flags
//   id_rw/id_regwr    ID destination and write enable
//   id_memtoreg       ID instruction is a load
//   br_taken          branch in EX resolved taken (qualified by EX valid)
//   mem_wait          data memory not ready, freeze the whole pipe
//   pc_en, ifid_en    PC / IF-ID load enables (combinational)
//   ifid_flush        IF/ID loads a bubble (combinational)
//   ex_bubble         ID/EX loads a bubble (combinational)
//   fwd_sel           per-source EX operand select, 2 bits per source
//   ex/mem/wb_valid   stage occupancy
//   wb_rw, wb_regwr   WB destination and valid-qualified write enable
//   stall_cnt         load-use stall cycles   (only with PIPE_PERF_CNT_EN)
//   flush_cnt         taken-branch flushes    (only with PIPE_PERF_CNT_EN)
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating perf counters.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int N_SRC  = 2
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    id_valid,
   input  logic [N_SRC*REG_AW-1:0] id_src,
   input  logic [N_SRC-1:0]        id_src_used,
   input  logic [REG_AW-1:0]       id_rw,
   input  logic                    id_regwr,
   input  logic                    id_memtoreg,
   input  logic                    br_taken,
   input  logic                    mem_wait,
   output logic                    pc_en,
   output logic                    ifid_en,
   output logic                    ifid_flush,
   output logic                    ex_bubble,
   output logic [2*N_SRC-1:0]      fwd_sel,
   output logic                    ex_valid,
   output logic                    mem_valid,
   output logic                    wb_valid,
   output logic [REG_AW-1:0]       wb_rw,
   output logic                    wb_regwr
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]             stall_cnt,
   output logic [31:0]             flush_cnt
`endif
);

   stage_rec_t ex_r;
   stage_rec_t mem_r;
   stage_rec_t wb_r;
   stage_rec_t id_rec_s;

   logic [N_SRC-1:0]   hit_ex_s;
   logic [N_SRC-1:0]   hit_mem_s;
   logic [N_SRC-1:0]   hit_lu_s;
   logic [2*N_SRC-1:0] fwd_next_s;

   logic tb_s;
   logic lu_s;
   logic squash_s;
   logic pc_en_s;
   logic ifid_en_s;
   logic ifid_flush_s;
   logic ex_bubble_s;
   logic unused_wb_bits;

   assign id_rec_s = '{valid: id_valid, rw: REC_AW_MAX'(id_rw), regwr: id_regwr, memtoreg: id_memtoreg};

   // Per-source matchers: EX and MEM for forwarding, EX again for load-use.
   for (genvar s = 0; s < N_SRC; s++) begin : g_src
      logic [REC_AW_MAX-1:0] src_ext;
      assign src_ext = REC_AW_MAX'(id_src[s*REG_AW +: REG_AW]);

      src_match u_fwd_ex  (.src(src_ext), .used(id_src_used[s]), .rec(ex_r),  .hit(hit_ex_s[s]));
      src_match u_fwd_mem (.src(src_ext), .used(id_src_used[s]), .rec(mem_r), .hit(hit_mem_s[s]));
      src_match u_lu      (.src(src_ext), .used(id_src_used[s]), .rec(ex_r),  .hit(hit_lu_s[s]));
   end

   assign tb_s     = br_taken & ex_r.valid;
   assign lu_s     = id_valid & ex_r.memtoreg & (|hit_lu_s);
   assign squash_s = tb_s | lu_s;

   // Forwarding selects for the instruction about to enter EX; the nearest
   // producer (EX) wins over MEM. A WB hit needs no forward: the register
   // file is write-through.
   always_comb begin
      fwd_next_s = '0;
      for (int s = 0; s < N_SRC; s++) begin
         if (hit_ex_s[s]) begin
            fwd_next_s[2*s +: 2] = FWD_EXMEM;
         end else if (hit_mem_s[s]) begin
            fwd_next_s[2*s +: 2] = FWD_MEMWB;
         end else begin
            fwd_next_s[2*s +: 2] = FWD_RF;
         end
      end
   end

   // Pipeline control with priority mem_wait > taken branch > load-use > normal.
   always_comb begin
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      ifid_flush_s = 1'b0;
      ex_bubble_s  = 1'b0;
      if (mem_wait) begin
         pc_en_s      = 1'b0;
         ifid_en_s    = 1'b0;
      end else if (tb_s) begin
         pc_en_s      = 1'b1;
         ifid_en_s    = 1'b1;
         ifid_flush_s = 1'b1;
         ex_bubble_s  = 1'b1;
      end else if (lu_s) begin
         ex_bubble_s  = 1'b1;
      end else begin
         pc_en_s      = 1'b1;
         ifid_en_s    = 1'b1;
      end
   end

   // Enables are forced low while reset is held.
   assign pc_en      = pc_en_s      & rst_n;
   assign ifid_en    = ifid_en_s    & rst_n;
   assign ifid_flush = ifid_flush_s & rst_n;
   assign ex_bubble  = ex_bubble_s  & rst_n;

   // Scoreboard shift and forwarding-select register; frozen during mem_wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_r    <= REC_EMPTY;
         mem_r   <= REC_EMPTY;
         wb_r    <= REC_EMPTY;
         fwd_sel <= '0;
      end else if (mem_wait) begin
         ex_r    <= ex_r;
         mem_r   <= mem_r;
         wb_r    <= wb_r;
         fwd_sel <= fwd_sel;
      end else begin
         wb_r  <= mem_r;
         mem_r <= ex_r;
         if (squash_s) begin
            ex_r    <= REC_EMPTY;
            fwd_sel <= '0;
         end else begin
            ex_r    <= id_rec_s;
            fwd_sel <= fwd_next_s;
         end
      end
   end

   assign ex_valid       = ex_r.valid;
   assign mem_valid      = mem_r.valid;
   assign wb_valid       = wb_r.valid;
   assign wb_rw          = wb_r.rw[REG_AW-1:0];
   assign wb_regwr       = wb_r.valid & wb_r.regwr;
   assign unused_wb_bits = ^{wb_r.memtoreg, wb_r.rw};

`ifdef PIPE_PERF_CNT_EN
   // Saturating counters of load-use stall cycles and taken-branch flushes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (!mem_wait && !tb_s && lu_s && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end else begin
            stall_cnt <= stall_cnt;
         end
         if (!mem_wait && tb_s && (flush_cnt != 32'hFFFF_FFFF)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end else begin
            flush_cnt <= flush_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared against a stage-list reference model of the hazard rules.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int N_SRC  = 2;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    id_valid = 1'b0;
   logic [N_SRC*REG_AW-1:0] id_src = '0;
   logic [N_SRC-1:0]        id_src_used = '0;
   logic [REG_AW-1:0]       id_rw = '0;
   logic                    id_regwr = 1'b0;
   logic                    id_memtoreg = 1'b0;
   logic                    br_taken = 1'b0;
   logic                    mem_wait = 1'b0;
   logic                    pc_en, ifid_en, ifid_flush, ex_bubble;
   logic [2*N_SRC-1:0]      fwd_sel;
   logic                    ex_valid, mem_valid, wb_valid;
   logic [REG_AW-1:0]       wb_rw;
   logic                    wb_regwr;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0]             stall_cnt, flush_cnt;
`endif

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .N_SRC(N_SRC)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .id_rw(id_rw), .id_regwr(id_regwr),
      .id_memtoreg(id_memtoreg), .br_taken(br_taken), .mem_wait(mem_wait),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .ex_bubble(ex_bubble), .fwd_sel(fwd_sel), .ex_valid(ex_valid),
      .mem_valid(mem_valid), .wb_valid(wb_valid), .wb_rw(wb_rw),
      .wb_regwr(wb_regwr)
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: stage list, index 0 = EX, 1 = MEM, 2 = WB.
   typedef struct {
      bit v;
      int rw;
      bit wr;
      bit ld;
   } rec_t;

   rec_t m_st[3];
   int   m_fwd[N_SRC];
   int   m_stall;
   int   m_flush;
   int   n_checks;
   int   n_pass;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_writer(input int k);
      return m_st[k].v && m_st[k].wr && (m_st[k].rw != 0);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) m_st[k] = '{v: 1'b0, rw: 0, wr: 1'b0, ld: 1'b0};
      for (int s = 0; s < N_SRC; s++) m_fwd[s] = 0;
      m_stall = 0;
      m_flush = 0;
   endtask

   task automatic check_regs(input string tag);
      logic [2*N_SRC-1:0] efwd;
      for (int s = 0; s < N_SRC; s++) efwd[2*s +: 2] = 2'(m_fwd[s]);
      check_eq({tag, "_valids"}, {29'd0, ex_valid, mem_valid, wb_valid},
               {29'd0, m_st[0].v, m_st[1].v, m_st[2].v});
      check_eq({tag, "_fwd"}, 32'(fwd_sel), 32'(efwd));
      check_eq({tag, "_wbwr"}, {31'd0, wb_regwr}, {31'd0, m_st[2].v && m_st[2].wr});
      if (m_st[2].v) check_eq({tag, "_wbrw"}, 32'(wb_rw), 32'(m_st[2].rw));
`ifdef PIPE_PERF_CNT_EN
      check_eq({tag, "_stallcnt"}, stall_cnt, 32'(m_stall));
      check_eq({tag, "_flushcnt"}, flush_cnt, 32'(m_flush));
`endif
   endtask

   // One pipeline cycle: called just after a rising edge.
   task automatic step(input bit v, input int rw, input bit wr, input bit ld,
                       input int s0, input int s1, input logic [1:0] used,
                       input bit br, input bit mw);
      int   srcs[N_SRC];
      bit   lu, tb;
      logic [3:0] een;
      rec_t nxt[3];
      int   nfwd[N_SRC];
      srcs[0] = s0;
      srcs[1] = s1;
      id_valid    = v;
      id_rw       = REG_AW'(rw);
      id_regwr    = wr;
      id_memtoreg = ld;
      id_src      = {REG_AW'(s1), REG_AW'(s0)};
      id_src_used = used;
      br_taken    = br;
      mem_wait    = mw;

      lu = 1'b0;
      if (v && m_writer(0) && m_st[0].ld)
         for (int s = 0; s < N_SRC; s++)
            if (used[s] && srcs[s] == m_st[0].rw) lu = 1'b1;
      tb = br && m_st[0].v;
      if (mw)      een = 4'b0000;
      else if (tb) een = 4'b1111;
      else if (lu) een = 4'b0001;
      else         een = 4'b1100;

      @(negedge clk);
      check_eq("enables{pc,ifid,flush,bubble}", {28'd0, pc_en, ifid_en, ifid_flush, ex_bubble}, {28'd0, een});

      if (!mw) begin
         for (int s = 0; s < N_SRC; s++) begin
            nfwd[s] = 0;
            if (used[s])
               for (int k = 1; k >= 0; k--)
                  if (m_writer(k) && m_st[k].rw == srcs[s]) nfwd[s] = k + 1;
         end
         nxt[2] = m_st[1];
         nxt[1] = m_st[0];
         if (tb || lu) begin
            nxt[0] = '{v: 1'b0, rw: 0, wr: 1'b0, ld: 1'b0};
            for (int s = 0; s < N_SRC; s++) nfwd[s] = 0;
         end else begin
            nxt[0] = '{v: v, rw: rw, wr: wr, ld: ld};
         end
         if (tb) m_flush++;
         else if (lu) m_stall++;
      end else begin
         nxt = m_st;
         nfwd = m_fwd;
      end

      @(posedge clk);
      #1;
      m_st  = nxt;
      m_fwd = nfwd;
      check_regs("cycle");
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      model_reset();

      // Enables must be forced low while reset is held, even with live ID.
      id_valid = 1'b1;
      id_src_used = 2'b11;
      #12;
      check_eq("reset_enables", {28'd0, pc_en, ifid_en, ifid_flush, ex_bubble}, 32'd0);
      check_regs("reset");
      id_valid = 1'b0;
      id_src_used = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_regs("post_reset");

      // Dependent ALU op: add r3, then consumer of r3 (EX fwd), then another (MEM fwd).
      step(1, 3, 1, 0, 0, 0, 2'b00, 0, 0);
      step(1, 4, 1, 0, 3, 0, 2'b01, 0, 0);
      check_eq("dep_alu_exmem", 32'(fwd_sel[1:0]), 32'd1);
      step(1, 6, 1, 0, 3, 0, 2'b01, 0, 0);
      check_eq("dep_alu_memwb", 32'(fwd_sel[1:0]), 32'd2);

      // Load-use on src1: one stall, then MEM/WB forward.
      step(1, 5, 1, 1, 0, 0, 2'b00, 0, 0);
      step(1, 7, 1, 0, 0, 5, 2'b10, 0, 0);
      step(1, 7, 1, 0, 0, 5, 2'b10, 0, 0);
      check_eq("load_use_fwd", 32'(fwd_sel), 32'h8);

      // Register zero writer never forwards or stalls.
      step(1, 0, 1, 1, 0, 0, 2'b00, 0, 0);
      step(1, 2, 1, 0, 0, 0, 2'b11, 0, 0);
      check_eq("reg_zero_fwd", 32'(fwd_sel), 32'd0);

      // Taken branch coinciding with load-use.
      step(1, 9, 1, 1, 0, 0, 2'b00, 0, 0);
      step(1, 1, 1, 0, 9, 0, 2'b01, 1, 0);
      check_eq("tb_lu_ex_invalid", {31'd0, ex_valid}, 32'd0);

      // mem_wait for three cycles mid-stream, then resume.
      step(1, 8, 1, 0, 0, 0, 2'b00, 0, 0);
      step(1, 10, 1, 0, 8, 0, 2'b01, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 11, 1, 0, 10, 8, 2'b11, 0, 1);
      step(1, 11, 1, 0, 10, 8, 2'b11, 0, 0);

      // Randomized traffic over a small register set to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 4, $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
      end

      // Asynchronous reset mid-stream: state clears with no clock edge.
      step(1, 2, 1, 0, 1, 2, 2'b11, 0, 0);
      step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("async_reset_valids", {29'd0, ex_valid, mem_valid, wb_valid}, 32'd0);
      check_eq("async_reset_fwd", 32'(fwd_sel), 32'd0);
      check_eq("async_reset_enables", {28'd0, pc_en, ifid_en, ifid_flush, ex_bubble}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_regs("after_async_reset");
      for (int i = 0; i < 100; i++) begin
         step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom_range(0, 3)), $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
